// File: rtl/amiq_dvcon_purple_pkg.sv
// Shared types for the purple receive path.
// Contents:
//   purple_txn_t     - one captured purple transaction (three 32-bit fields)
//   beat_e           - downstream beat index / serializer state
//   purple_field_sel - selects one field of a transaction by beat index
package amiq_dvcon_purple_pkg;

    localparam int PURPLE_NUM_FIELDS = 3;
    localparam int PURPLE_FIELD_W    = 32;

    typedef struct packed {
        logic [PURPLE_FIELD_W-1:0] f0;
        logic [PURPLE_FIELD_W-1:0] f1;
        logic [PURPLE_FIELD_W-1:0] f2;
    } purple_txn_t;

    typedef enum logic [1:0] {
        BEAT_F0 = 2'd0,
        BEAT_F1 = 2'd1,
        BEAT_F2 = 2'd2
    } beat_e;

    function automatic logic [PURPLE_FIELD_W-1:0] purple_field_sel(
        input purple_txn_t txn,
        input beat_e       beat
    );
        case (beat)
            BEAT_F0: return txn.f0;
            BEAT_F1: return txn.f1;
            default: return txn.f2;
        endcase
    endfunction

endpackage

// File: rtl/amiq_dvcon_purple_fifo.sv
// Synchronous FIFO of purple transactions with registered storage.
// Ports:
//   clk, rst          - clock, synchronous active-high reset (pointers/level only)
//   push_i, data_i    - write request and transaction; ignored when full
//   pop_i             - remove head entry; ignored when empty
//   head_o            - entry at the read pointer (valid when !empty_o)
//   full_o, empty_o   - occupancy flags derived from the registered level
//   level_o           - number of stored transactions
module amiq_dvcon_purple_fifo
    import amiq_dvcon_purple_pkg::*;
#(
    parameter int DEPTH = 8,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        push_i,
    input  purple_txn_t data_i,
    input  logic        pop_i,
    output purple_txn_t head_o,
    output logic        full_o,
    output logic        empty_o,
    output logic [AW:0] level_o
);

    purple_txn_t   mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   level_q, level_d;
    logic          push_ok, pop_ok;

    assign full_o  = (level_q == (AW+1)'(DEPTH));
    assign empty_o = (level_q == '0);
    assign level_o = level_q;
    assign head_o  = mem_q[rd_ptr_q];

    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;

    always_comb begin
        level_d = level_q;
        case ({push_ok, pop_ok})
            2'b10:   level_d = level_q + (AW+1)'(1);
            2'b01:   level_d = level_q - (AW+1)'(1);
            default: level_d = level_q;
        endcase
    end

    // Storage is data only and needs no reset; stale entries are never read
    // because the pointers and level are cleared.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    // DEPTH is a power of two, so the pointers wrap by natural overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
            level_q <= level_d;
        end
    end

endmodule

// File: rtl/amiq_dvcon_purple_rx.sv
// Purple protocol sink: captures transactions into a FIFO and replays each
// one downstream as three 32-bit beats on a ready/valid stream. Transactions
// arriving while the FIFO is full are dropped and counted.
// Ports:
//   clk, rst                  - clock, synchronous active-high reset
//   field0..2, valid          - purple input (no back-pressure)
//   out_data/out_beat/out_last/out_valid, out_ready - downstream beat stream
//   level                     - FIFO occupancy in transactions
//   drop_cnt, overflow        - saturating drop count and sticky drop flag
//   clr_stats                 - clears drop_cnt/overflow
module amiq_dvcon_purple_rx
    import amiq_dvcon_purple_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int CNT_W = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [31:0]              field0,
    input  logic [31:0]              field1,
    input  logic [31:0]              field2,
    input  logic                     valid,
    output logic [31:0]              out_data,
    output logic [1:0]               out_beat,
    output logic                     out_last,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   level,
    output logic [CNT_W-1:0]         drop_cnt,
    output logic                     overflow,
    input  logic                     clr_stats
);

    purple_txn_t      in_txn, head;
    logic             fifo_full, fifo_empty;
    logic             push, drop, handshake, pop;
    beat_e            beat_q, beat_d;
    logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
    logic             overflow_q, overflow_d;

    assign in_txn = '{f0: field0, f1: field1, f2: field2};

    // Full is taken from the registered level, so a pop in the same cycle
    // never makes room for the incoming transaction.
    assign push = valid && !fifo_full;
    assign drop = valid && fifo_full;

    assign handshake = out_valid && out_ready;
    assign pop       = handshake && (beat_q == BEAT_F2);

    amiq_dvcon_purple_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .data_i  (in_txn),
        .pop_i   (pop),
        .head_o  (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .level_o (level)
    );

    always_comb begin
        beat_d = beat_q;
        if (handshake) begin
            case (beat_q)
                BEAT_F0: beat_d = BEAT_F1;
                BEAT_F1: beat_d = BEAT_F2;
                default: beat_d = BEAT_F0;
            endcase
        end
    end

    // clr_stats wins over accumulation but still records a drop in the
    // same cycle, so no drop is ever lost across a clear.
    always_comb begin
        drop_cnt_d = drop_cnt_q;
        overflow_d = overflow_q;
        if (clr_stats) begin
            drop_cnt_d = drop ? CNT_W'(1) : '0;
            overflow_d = drop;
        end else if (drop) begin
            drop_cnt_d = (&drop_cnt_q) ? drop_cnt_q : drop_cnt_q + CNT_W'(1);
            overflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            beat_q     <= BEAT_F0;
            drop_cnt_q <= '0;
            overflow_q <= 1'b0;
        end else begin
            beat_q     <= beat_d;
            drop_cnt_q <= drop_cnt_d;
            overflow_q <= overflow_d;
        end
    end

    // All outputs derive from registered state only.
    assign out_valid = !fifo_empty;
    assign out_beat  = beat_q;
    assign out_last  = (beat_q == BEAT_F2);
    assign out_data  = out_valid ? purple_field_sel(head, beat_q) : '0;
    assign drop_cnt  = drop_cnt_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_amiq_dvcon_purple_rx.sv
module tb_amiq_dvcon_purple_rx;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] field0, field1, field2;
    logic        valid, out_ready, clr_stats;
    logic [31:0] out_data, b_out_data;
    logic [1:0]  out_beat, b_out_beat;
    logic        out_last, out_valid, overflow;
    logic        b_out_last, b_out_valid, b_overflow;
    logic [3:0]  level, b_level;
    logic [15:0] drop_cnt;
    logic [3:0]  b_drop_cnt;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    amiq_dvcon_purple_rx #(.DEPTH(8), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .field0(field0), .field1(field1), .field2(field2),
        .valid(valid), .out_data(out_data), .out_beat(out_beat), .out_last(out_last),
        .out_valid(out_valid), .out_ready(out_ready), .level(level),
        .drop_cnt(drop_cnt), .overflow(overflow), .clr_stats(clr_stats)
    );

    // Narrow-counter instance sharing all stimulus, used for saturation.
    amiq_dvcon_purple_rx #(.DEPTH(8), .CNT_W(4)) dut_c4 (
        .clk(clk), .rst(rst), .field0(field0), .field1(field1), .field2(field2),
        .valid(valid), .out_data(b_out_data), .out_beat(b_out_beat), .out_last(b_out_last),
        .out_valid(b_out_valid), .out_ready(out_ready), .level(b_level),
        .drop_cnt(b_drop_cnt), .overflow(b_overflow), .clr_stats(clr_stats)
    );

    function automatic logic [31:0] fv(input int t, input int k);
        return 32'hA500_0000 | (32'(t) << 8) | 32'(k);
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic push_txn(input int t);
        field0 = fv(t, 0); field1 = fv(t, 1); field2 = fv(t, 2);
        valid = 1'b1;
        tick();
        valid = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; valid = 1'b0; out_ready = 1'b0; clr_stats = 1'b0;
        field0 = '0; field1 = '0; field2 = '0;
        tick(); tick();
        n_cmp++;
        if ({out_valid, out_data, out_beat, out_last, level, drop_cnt, overflow} !== '0) begin
            n_fail++;
            $display("FAIL reset: valid=%b data=%h beat=%0d last=%b level=%0d drop=%0d ovf=%b, required all 0",
                     out_valid, out_data, out_beat, out_last, level, drop_cnt, overflow);
        end
        rst = 1'b0;
    endtask

    task automatic test_single;
        field0 = 32'h1111_1111; field1 = 32'h2222_2222; field2 = 32'h3333_3333;
        valid = 1'b1; out_ready = 1'b1;
        n_cmp++;
        if ({out_valid, level} !== {1'b0, 4'd0}) begin
            n_fail++;
            $display("FAIL single_push_cycle: valid=%b level=%0d, required 0/0", out_valid, level);
        end
        tick();
        valid = 1'b0;
        n_cmp++;
        if ({out_valid, out_beat, out_last, out_data, level} !== {1'b1, 2'd0, 1'b0, 32'h1111_1111, 4'd1}) begin
            n_fail++;
            $display("FAIL single_beat0: valid=%b beat=%0d last=%b data=%h level=%0d, required 1/0/0/11111111/1",
                     out_valid, out_beat, out_last, out_data, level);
        end
        tick();
        n_cmp++;
        if ({out_valid, out_beat, out_last, out_data} !== {1'b1, 2'd1, 1'b0, 32'h2222_2222}) begin
            n_fail++;
            $display("FAIL single_beat1: valid=%b beat=%0d last=%b data=%h, required 1/1/0/22222222",
                     out_valid, out_beat, out_last, out_data);
        end
        tick();
        n_cmp++;
        if ({out_valid, out_beat, out_last, out_data} !== {1'b1, 2'd2, 1'b1, 32'h3333_3333}) begin
            n_fail++;
            $display("FAIL single_beat2: valid=%b beat=%0d last=%b data=%h, required 1/2/1/33333333",
                     out_valid, out_beat, out_last, out_data);
        end
        tick();
        n_cmp++;
        if ({out_valid, out_beat, out_data, level} !== {1'b0, 2'd0, 32'd0, 4'd0}) begin
            n_fail++;
            $display("FAIL single_done: valid=%b beat=%0d data=%h level=%0d, required 0/0/0/0",
                     out_valid, out_beat, out_data, level);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_back_to_back;
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) push_txn(16 + i);
        n_cmp++;
        if ({level, drop_cnt, overflow} !== {4'd8, 16'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL b2b_full: level=%0d drop=%0d ovf=%b, required 8/0/0", level, drop_cnt, overflow);
        end
        push_txn(99);
        n_cmp++;
        if ({level, drop_cnt, overflow, b_drop_cnt} !== {4'd8, 16'd1, 1'b1, 4'd1}) begin
            n_fail++;
            $display("FAIL b2b_drop: level=%0d drop=%0d ovf=%b drop4=%0d, required 8/1/1/1",
                     level, drop_cnt, overflow, b_drop_cnt);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            for (int k = 0; k < 3; k++) begin
                n_cmp++;
                if ({out_valid, out_beat, out_last, out_data} !== {1'b1, 2'(k), (k == 2), fv(16 + i, k)}) begin
                    n_fail++;
                    $display("FAIL b2b_drain[%0d.%0d]: valid=%b beat=%0d last=%b data=%h, required 1/%0d/%0b/%h",
                             i, k, out_valid, out_beat, out_last, out_data, k, (k == 2), fv(16 + i, k));
                end
                tick();
            end
        end
        out_ready = 1'b0;
        n_cmp++;
        if ({out_valid, level} !== {1'b0, 4'd0}) begin
            n_fail++;
            $display("FAIL b2b_empty: valid=%b level=%0d, required 0/0", out_valid, level);
        end
    endtask

    task automatic test_stall;
        int idx;
        int cyc;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) push_txn(40 + i);
        idx = 0;
        cyc = 0;
        // Ready pattern 1,0,0 repeating; each cycle the outputs must show
        // exactly the next unconsumed beat, stalled or not.
        while (idx < 9 && cyc < 60) begin
            n_cmp++;
            if ({out_valid, out_beat, out_data} !== {1'b1, 2'(idx % 3), fv(40 + idx / 3, idx % 3)}) begin
                n_fail++;
                $display("FAIL stall[cyc %0d]: valid=%b beat=%0d data=%h, required 1/%0d/%h",
                         cyc, out_valid, out_beat, out_data, idx % 3, fv(40 + idx / 3, idx % 3));
            end
            out_ready = (cyc % 3 == 0);
            tick();
            if (out_ready) idx++;
            cyc++;
        end
        out_ready = 1'b0;
        n_cmp++;
        if ({idx == 9, out_valid, level} !== {1'b1, 1'b0, 4'd0}) begin
            n_fail++;
            $display("FAIL stall_end: beats=%0d valid=%b level=%0d, required 9/0/0", idx, out_valid, level);
        end
    endtask

    task automatic test_full_pop;
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) push_txn(64 + i);
        out_ready = 1'b1;
        tick(); tick();
        n_cmp++;
        if ({out_beat, level} !== {2'd2, 4'd8}) begin
            n_fail++;
            $display("FAIL fullpop_pre: beat=%0d level=%0d, required 2/8", out_beat, level);
        end
        field0 = fv(200, 0); field1 = fv(200, 1); field2 = fv(200, 2);
        valid = 1'b1;
        tick();
        valid = 1'b0;
        n_cmp++;
        if ({level, drop_cnt, out_beat, out_data} !== {4'd7, 16'd2, 2'd0, fv(65, 0)}) begin
            n_fail++;
            $display("FAIL fullpop: level=%0d drop=%0d beat=%0d data=%h, required 7/2/0/%h",
                     level, drop_cnt, out_beat, out_data, fv(65, 0));
        end
        for (int i = 1; i < 8; i++) begin
            for (int k = 0; k < 3; k++) begin
                n_cmp++;
                if (out_data !== fv(64 + i, k)) begin
                    n_fail++;
                    $display("FAIL fullpop_drain[%0d.%0d]: data=%h, required %h", i, k, out_data, fv(64 + i, k));
                end
                tick();
            end
        end
        out_ready = 1'b0;
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL fullpop_empty: valid=%b, required 0", out_valid);
        end
    endtask

    task automatic test_clr_stats;
        for (int i = 0; i < 8; i++) push_txn(80 + i);
        clr_stats = 1'b1;
        push_txn(90);
        clr_stats = 1'b0;
        n_cmp++;
        if ({drop_cnt, overflow, b_drop_cnt, b_overflow} !== {16'd1, 1'b1, 4'd1, 1'b1}) begin
            n_fail++;
            $display("FAIL clr_with_drop: drop=%0d ovf=%b drop4=%0d ovf4=%b, required 1/1/1/1",
                     drop_cnt, overflow, b_drop_cnt, b_overflow);
        end
        clr_stats = 1'b1;
        tick();
        clr_stats = 1'b0;
        n_cmp++;
        if ({drop_cnt, overflow} !== {16'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL clr_alone: drop=%0d ovf=%b, required 0/0", drop_cnt, overflow);
        end
        for (int i = 0; i < 20; i++) push_txn(100 + i);
        n_cmp++;
        if ({drop_cnt, b_drop_cnt, b_overflow, level} !== {16'd20, 4'd15, 1'b1, 4'd8}) begin
            n_fail++;
            $display("FAIL saturate: drop16=%0d drop4=%0d ovf4=%b level=%0d, required 20/15/1/8",
                     drop_cnt, b_drop_cnt, b_overflow, level);
        end
    endtask

    task automatic test_reset_mid;
        rst = 1'b1; tick(); rst = 1'b0;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) push_txn(120 + i);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        n_cmp++;
        if ({out_beat, level} !== {2'd1, 4'd3}) begin
            n_fail++;
            $display("FAIL rstmid_pre: beat=%0d level=%0d, required 1/3", out_beat, level);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_cmp++;
        if ({out_valid, out_data, out_beat, out_last, level, drop_cnt, overflow} !== '0) begin
            n_fail++;
            $display("FAIL rstmid: valid=%b data=%h beat=%0d last=%b level=%0d drop=%0d ovf=%b, required all 0",
                     out_valid, out_data, out_beat, out_last, level, drop_cnt, overflow);
        end
        push_txn(130);
        n_cmp++;
        if ({out_valid, out_beat, out_data, level} !== {1'b1, 2'd0, fv(130, 0), 4'd1}) begin
            n_fail++;
            $display("FAIL rstmid_new: valid=%b beat=%0d data=%h level=%0d, required 1/0/%h/1",
                     out_valid, out_beat, out_data, level, fv(130, 0));
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_stall();
        test_full_pop();
        test_clr_stats();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
